// File: rtl/spi_mram_bridge.sv
// SPI (mode 3) slave that turns framed header/address/data bytes into memory
// read/write commands and streams read words back out on MISO.
module spi_mram_bridge #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int TA_BYTES = 1
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst,
  input  logic              SCLK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [2:0]        cmd_rws,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_abort,
  output logic              err_overrun,
  output logic              err_underrun,
  output logic [2:0]        dbg_state
);
  localparam int         AB      = (ADDR_W + 7) / 8;
  localparam logic [6:0] AB_LAST = 7'(AB - 1);
  localparam logic [6:0] DB_LAST = 7'(DATA_W / 8 - 1);
  localparam logic [6:0] TA_LAST = 7'(TA_BYTES - 1);
  localparam logic [4:0] TX_LAST = 5'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_WDATA, S_TA, S_RSHIFT, S_DONE
  } state_t;

  state_t              state;
  logic [2:0]          sclk_s, ssel_s, mosi_s;
  logic [1:0]          settle;
  logic                armed;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_sr;
  logic                byte_done;
  logic [2:0]          rws_q;
  logic                is_wr;
  logic [4:0]          n_words, word_cnt, rd_issued, tx_words;
  logic [6:0]          byte_cnt;
  logic [AB*8-1:0]     addr_acc;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   wacc, buf_q, tx_sr;
  logic                buf_full;
  logic [4:0]          tx_cnt;
  logic                miso_q;

  logic                sclk_rise, sclk_fall, ssel_rise, ssel_fall, sel_active;
  logic                cmd_pend, tx_load;
  logic [AB*8+7:0]     addr_cat;
  logic [DATA_W+7:0]   wcat;
  logic [ADDR_W-1:0]   base_addr;
  logic [DATA_W-1:0]   wnext;

  // cmd_* is a valid/ready channel: once cmd_valid is high, cmd_we/rws/addr/wdata
  // stay frozen until the cycle where cmd_valid && cmd_ready, which is the transfer.
  always_comb begin
    sclk_rise  = sclk_s[1] & ~sclk_s[2];
    sclk_fall  = ~sclk_s[1] & sclk_s[2];
    ssel_fall  = ssel_s[2] & ~ssel_s[1];
    ssel_rise  = ~ssel_s[2] & ssel_s[1];
    sel_active = ~ssel_s[1];
    cmd_pend   = cmd_valid && !cmd_ready;
    addr_cat   = {rx_sr, addr_acc};
    base_addr  = addr_cat[ADDR_W+7:8];
    wcat       = {rx_sr, wacc};
    wnext      = wcat[DATA_W+7:8];
    tx_load    = (state == S_TA && byte_done && byte_cnt == TA_LAST) ||
                 (state == S_RSHIFT && sel_active && sclk_fall &&
                  tx_cnt == TX_LAST && tx_words != n_words);
  end

  assign MISO      = miso_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state <= S_IDLE;
      sclk_s <= 3'b111; ssel_s <= 3'b111; mosi_s <= 3'b000;
      settle <= '0; armed <= 1'b0; bit_cnt <= '0; rx_sr <= '0; byte_done <= 1'b0;
      rws_q <= '0; is_wr <= 1'b0; n_words <= '0; word_cnt <= '0;
      rd_issued <= '0; tx_words <= '0; byte_cnt <= '0; addr_acc <= '0;
      cur_addr <= '0; wacc <= '0; buf_q <= '0; tx_sr <= '0; buf_full <= 1'b0;
      tx_cnt <= '0; miso_q <= 1'b0;
      cmd_valid <= 1'b0; cmd_we <= 1'b0; cmd_rws <= '0; cmd_addr <= '0; cmd_wdata <= '0;
      frame_done <= 1'b0; err_abort <= 1'b0; err_overrun <= 1'b0; err_underrun <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], SCLK};
      ssel_s <= {ssel_s[1:0], SSEL};
      mosi_s <= {mosi_s[1:0], MOSI};
      // A frame only starts after SSEL has been seen idle since reset, so a
      // frame interrupted by reset is ignored until its next falling edge.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && ssel_s == 3'b111) armed <= 1'b1;
      frame_done <= 1'b0;
      byte_done  <= 1'b0;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (sel_active && sclk_rise) begin
        rx_sr     <= {rx_sr[6:0], mosi_s[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end

      if (state != S_RSHIFT) begin
        miso_q <= 1'b0;
      end else if (sel_active && sclk_fall) begin
        miso_q <= tx_sr[DATA_W-1];
        tx_sr  <= tx_sr << 1;
        tx_cnt <= tx_cnt + 5'd1;
        if (tx_cnt == TX_LAST) tx_cnt <= '0;
      end

      if (tx_load) begin
        tx_words <= tx_words + 5'd1;
        if (buf_full) begin
          tx_sr    <= buf_q;
          buf_full <= 1'b0;
        end else begin
          tx_sr        <= '0;
          err_underrun <= 1'b1;
        end
      end

      if (ssel_fall && armed) begin
        state <= S_HDR;
        err_abort <= 1'b0; err_overrun <= 1'b0; err_underrun <= 1'b0;
        bit_cnt <= '0; byte_cnt <= '0; word_cnt <= '0; rd_issued <= '0;
        tx_words <= '0; tx_cnt <= '0; buf_full <= 1'b0;
      end else if (ssel_rise) begin
        if (state == S_DONE) begin
          state      <= S_IDLE;
          frame_done <= 1'b1;
        end else if (state != S_IDLE) begin
          state     <= S_IDLE;
          err_abort <= 1'b1;
        end
      end else if (byte_done) begin
        case (state)
          S_HDR: begin
            rws_q    <= rx_sr[7:5];
            is_wr    <= rx_sr[5];
            n_words  <= rx_sr[0] ? ({1'b0, rx_sr[4:1]} + 5'd1) : 5'd1;
            byte_cnt <= '0;
            state    <= S_ADDR;
          end
          S_ADDR: begin
            addr_acc <= addr_cat[AB*8+7:8];
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == AB_LAST) begin
              byte_cnt <= '0;
              if (is_wr) begin
                cur_addr <= base_addr;
                state    <= S_WDATA;
              end else begin
                state <= S_TA;
                if (!cmd_pend) begin
                  cmd_valid <= 1'b1; cmd_we <= 1'b0; cmd_rws <= rws_q;
                  cmd_addr  <= base_addr;
                  cur_addr  <= base_addr + ADDR_W'(1);
                  rd_issued <= 5'd1;
                end else begin
                  cur_addr <= base_addr;
                end
              end
            end
          end
          S_WDATA: begin
            wacc     <= wnext;
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == DB_LAST) begin
              byte_cnt <= '0;
              word_cnt <= word_cnt + 5'd1;
              cur_addr <= cur_addr + ADDR_W'(1);
              if (cmd_pend) begin
                err_overrun <= 1'b1;
              end else begin
                cmd_valid <= 1'b1; cmd_we <= 1'b1; cmd_rws <= rws_q;
                cmd_addr  <= cur_addr; cmd_wdata <= wnext;
              end
              if (word_cnt + 5'd1 == n_words) state <= S_DONE;
            end
          end
          S_TA: begin
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == TA_LAST) begin
              byte_cnt <= '0;
              tx_cnt   <= '0;
              state    <= S_RSHIFT;
            end
          end
          S_RSHIFT: begin
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == DB_LAST) begin
              byte_cnt <= '0;
              word_cnt <= word_cnt + 5'd1;
              if (word_cnt + 5'd1 == n_words) state <= S_DONE;
            end
          end
          default: ;
        endcase
      end

      // Returned read data lands in the prefetch buffer and immediately
      // requests the next word so it is ready before the next word boundary.
      if (rd_valid && (state == S_TA || state == S_RSHIFT)) begin
        if (buf_full && !tx_load) err_overrun <= 1'b1;
        buf_q    <= rd_data;
        buf_full <= 1'b1;
        if (rd_issued != n_words && !cmd_pend) begin
          cmd_valid <= 1'b1; cmd_we <= 1'b0; cmd_rws <= rws_q;
          cmd_addr  <= cur_addr;
          cur_addr  <= cur_addr + ADDR_W'(1);
          rd_issued <= rd_issued + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_mram_bridge.sv
// Directed bench for spi_mram_bridge: SPI host driver, memory responder,
// command scoreboard and final report.
module tb_spi_mram_bridge;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int CW     = 1 + ADDR_W + DATA_W;

  logic              FPGA_clk = 1'b0;
  logic              FPGA_rst = 1'b1;
  logic              SCLK = 1'b1, SSEL = 1'b1, MOSI = 1'b0;
  logic              MISO;
  logic              cmd_valid, cmd_ready, cmd_we;
  logic [2:0]        cmd_rws;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy, frame_done, err_abort, err_overrun, err_underrun;
  logic [2:0]        dbg_state;

  spi_mram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TA_BYTES(1)) dut (
    .FPGA_clk(FPGA_clk), .FPGA_rst(FPGA_rst), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
    .MISO(MISO), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_rws(cmd_rws), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .err_abort(err_abort), .err_overrun(err_overrun), .err_underrun(err_underrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 FPGA_clk = ~FPGA_clk;

  int n_chk = 0, n_fail = 0;
  int got_cnt = 0, extra_cnt = 0, fd_cnt = 0;
  int credit = 0, rd_timer = 0, rd_seq = 0;
  logic wr_accept = 1'b1;
  logic [CW-1:0] exp_q[$];
  logic [7:0] tx_b[0:15];
  logic [7:0] rx_b[0:15];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge FPGA_clk) if (frame_done) fd_cnt++;

  // memory responder and command scoreboard
  initial begin
    logic [CW-1:0] seen, e;
    cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge FPGA_clk);
      rd_valid = 1'b0;
      if (rd_timer > 0) begin
        rd_timer--;
        if (rd_timer == 0) begin
          rd_seq++;
          rd_valid = 1'b1;
          rd_data  = 16'hA000 + 16'(rd_seq);
        end
      end
      cmd_ready = 1'b0;
      if (!FPGA_rst && cmd_valid && (cmd_we ? wr_accept : (credit > 0 && rd_timer == 0))) begin
        cmd_ready = 1'b1;
        got_cnt++;
        seen = {cmd_we, cmd_addr, cmd_we ? cmd_wdata : 16'h0000};
        if (!cmd_we) begin
          credit--;
          rd_timer = 3;
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("cmd", 64'(seen), 64'(e));
        end else begin
          extra_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SCLK = 1'b0; MOSI = tx[i]; #60;
      rx[i] = MISO; SCLK = 1'b1; #60;
    end
  endtask

  task automatic run_frame(input int nb, input logic [15:0] credit_mask);
    logic [7:0] r;
    SSEL = 1'b0; #100;
    for (int i = 0; i < nb; i++) begin
      spi_byte(tx_b[i], r);
      rx_b[i] = r;
      if (credit_mask[i]) credit++;
    end
    #100; SSEL = 1'b1; #300;
  endtask

  task automatic set6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    tx_b[0] = b0; tx_b[1] = b1; tx_b[2] = b2; tx_b[3] = b3; tx_b[4] = b4; tx_b[5] = b5;
  endtask

  task automatic pulse_reset();
    @(negedge FPGA_clk); FPGA_rst = 1'b1;
    repeat (3) @(negedge FPGA_clk);
    FPGA_rst = 1'b0;
    repeat (10) @(negedge FPGA_clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, 64'({MISO, cmd_valid, cmd_we, cmd_rws, busy, frame_done}), 64'h0);
    check_eq({tag, "_err"}, 64'({err_abort, err_overrun, err_underrun}), 64'h0);
    check_eq({tag, "_addr"}, 64'(cmd_addr), 64'h0);
    check_eq({tag, "_wdata"}, 64'(cmd_wdata), 64'h0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'h0);
  endtask

  initial begin
    int g0, f0;
    logic [7:0] r;
    repeat (5) @(negedge FPGA_clk);
    check_reset_outs("reset");
    FPGA_rst = 1'b0;
    repeat (10) @(negedge FPGA_clk);

    // single write
    g0 = got_cnt; f0 = fd_cnt;
    exp_q.push_back({1'b1, 20'h12345, 16'hBEEF});
    set6(8'h20, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hBE);
    run_frame(6, 16'h0);
    check_eq("wr1_count", 64'(got_cnt - g0), 64'd1);
    check_eq("wr1_done", 64'(fd_cnt - f0), 64'd1);
    check_eq("wr1_busy", 64'(busy), 64'd0);

    // burst write with address wrap
    g0 = got_cnt; f0 = fd_cnt;
    exp_q.push_back({1'b1, 20'hFFFFE, 16'h1111});
    exp_q.push_back({1'b1, 20'hFFFFF, 16'h2222});
    exp_q.push_back({1'b1, 20'h00000, 16'h3333});
    exp_q.push_back({1'b1, 20'h00001, 16'h4444});
    set6(8'h27, 8'hFE, 8'hFF, 8'h0F, 8'h11, 8'h11);
    tx_b[6] = 8'h22; tx_b[7] = 8'h22; tx_b[8] = 8'h33; tx_b[9] = 8'h33;
    tx_b[10] = 8'h44; tx_b[11] = 8'h44;
    run_frame(12, 16'h0);
    check_eq("bw_count", 64'(got_cnt - g0), 64'd4);
    check_eq("bw_done", 64'(fd_cnt - f0), 64'd1);

    // burst read, memory accepts one command per word slot
    g0 = got_cnt; f0 = fd_cnt; rd_seq = 0; credit = 1;
    exp_q.push_back({1'b0, 20'h00010, 16'h0000});
    exp_q.push_back({1'b0, 20'h00011, 16'h0000});
    exp_q.push_back({1'b0, 20'h00012, 16'h0000});
    set6(8'h05, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 6; i < 11; i++) tx_b[i] = 8'h00;
    run_frame(11, 16'h00A0);
    check_eq("rd_w0", 64'({rx_b[5], rx_b[6]}), 64'hA001);
    check_eq("rd_w1", 64'({rx_b[7], rx_b[8]}), 64'hA002);
    check_eq("rd_w2", 64'({rx_b[9], rx_b[10]}), 64'hA003);
    check_eq("rd_errs", 64'({err_abort, err_overrun, err_underrun}), 64'h0);
    check_eq("rd_count", 64'(got_cnt - g0), 64'd3);
    check_eq("rd_done", 64'(fd_cnt - f0), 64'd1);

    // stalled 2-word burst write
    g0 = got_cnt; f0 = fd_cnt; wr_accept = 1'b0;
    set6(8'h23, 8'h00, 8'h01, 8'h00, 8'hFE, 8'hCA);
    tx_b[6] = 8'h0D; tx_b[7] = 8'hF0;
    run_frame(8, 16'h0);
    check_eq("stall_valid", 64'(cmd_valid), 64'd1);
    check_eq("stall_addr", 64'(cmd_addr), 64'h00100);
    check_eq("stall_wdata", 64'(cmd_wdata), 64'hCAFE);
    check_eq("stall_ovr", 64'(err_overrun), 64'd1);
    check_eq("stall_done", 64'(fd_cnt - f0), 64'd1);
    exp_q.push_back({1'b1, 20'h00100, 16'hCAFE});
    wr_accept = 1'b1;
    repeat (10) @(negedge FPGA_clk);
    check_eq("stall_count", 64'(got_cnt - g0), 64'd1);
    check_eq("stall_drain", 64'(cmd_valid), 64'd0);

    // underrun: memory never accepts the read
    f0 = fd_cnt; credit = 0;
    set6(8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h5A);
    tx_b[6] = 8'hA5;
    run_frame(7, 16'h0);
    check_eq("un_miso", 64'({rx_b[5], rx_b[6]}), 64'h0);
    check_eq("un_flag", 64'(err_underrun), 64'd1);
    check_eq("un_ovr_clr", 64'(err_overrun), 64'd0);
    check_eq("un_done", 64'(fd_cnt - f0), 64'd1);
    pulse_reset();
    check_eq("un_rst_valid", 64'(cmd_valid), 64'd0);

    // abort after 2 of 3 address bytes
    g0 = got_cnt; f0 = fd_cnt;
    set6(8'h20, 8'h45, 8'h23, 8'h00, 8'h00, 8'h00);
    run_frame(3, 16'h0);
    check_eq("ab_state", 64'(dbg_state), 64'h0);
    check_eq("ab_flag", 64'(err_abort), 64'd1);
    check_eq("ab_valid", 64'(cmd_valid), 64'd0);
    check_eq("ab_count", 64'(got_cnt - g0), 64'd0);
    check_eq("ab_done", 64'(fd_cnt - f0), 64'd0);

    // reset pulsed mid-write
    g0 = got_cnt; f0 = fd_cnt;
    set6(8'h20, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hBE);
    SSEL = 1'b0; #100;
    for (int i = 0; i < 5; i++) spi_byte(tx_b[i], r);
    check_eq("mr_busy", 64'(busy), 64'd1);
    @(negedge FPGA_clk); FPGA_rst = 1'b1;
    @(negedge FPGA_clk);
    check_reset_outs("mid_rst");
    FPGA_rst = 1'b0;
    spi_byte(tx_b[5], r);
    #100; SSEL = 1'b1; #300;
    check_eq("mr_count", 64'(got_cnt - g0), 64'd0);
    check_eq("mr_done", 64'(fd_cnt - f0), 64'd0);
    check_eq("mr_idle", 64'({busy, err_abort}), 64'h0);

    check_eq("extra_cmds", 64'(extra_cnt), 64'd0);
    check_eq("exp_left", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
